// File: rtl/comparator_binary_multiprecision.sv
// Iterative MSW-first signed/unsigned comparator for wide operands.
// One STEP_WORD_WIDTH slice per cycle; exits early on the first differing word.
module comparator_binary_multiprecision #(
  parameter int WORD_WIDTH      = 128,
  parameter int STEP_WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  clock_enable,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic                  A_eq_B,
  output logic                  A_lt_B_unsigned,
  output logic                  A_gt_B_unsigned,
  output logic                  A_lt_B_signed,
  output logic                  A_gt_B_signed
);
  localparam int STEP_WORD_COUNT = (WORD_WIDTH + STEP_WORD_WIDTH - 1) / STEP_WORD_WIDTH;
  localparam int PAD_WIDTH       = STEP_WORD_COUNT * STEP_WORD_WIDTH;
  localparam int CNT_WIDTH       = (STEP_WORD_COUNT > 1) ? $clog2(STEP_WORD_COUNT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STEP_WORD_COUNT - 1);

  typedef enum logic [1:0] {LOAD = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [PAD_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 eq_q, eq_d, ltu_q, ltu_d, gtu_q, gtu_d, lts_q, lts_d, gts_q, gts_d;
  logic                 load;

  logic [STEP_WORD_WIDTH-1:0] word_a, word_b;
  logic                       word_lt, sign_diff;

  assign word_a    = a_q[PAD_WIDTH-1 -: STEP_WORD_WIDTH];
  assign word_b    = b_q[PAD_WIDTH-1 -: STEP_WORD_WIDTH];
  assign word_lt   = (word_a < word_b);
  assign sign_diff = sign_a_q ^ sign_b_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    eq_d     = eq_q;
    ltu_d    = ltu_q;
    gtu_d    = gtu_q;
    lts_d    = lts_q;
    gts_d    = gts_q;
    load     = 1'b0;
    unique case (state_q)
      LOAD: load = input_valid;
      CALC: begin
        if (word_a != word_b) begin
          // Differing signs decide the signed order regardless of magnitude.
          eq_d    = 1'b0;
          ltu_d   = word_lt;
          gtu_d   = ~word_lt;
          lts_d   = sign_diff ? sign_a_q : word_lt;
          gts_d   = sign_diff ? sign_b_q : ~word_lt;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          eq_d    = 1'b1;
          ltu_d   = 1'b0;
          gtu_d   = 1'b0;
          lts_d   = 1'b0;
          gts_d   = 1'b0;
          state_d = DONE;
        end else begin
          a_d   = a_q << STEP_WORD_WIDTH;
          b_d   = b_q << STEP_WORD_WIDTH;
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      DONE: begin
        if (output_ready) begin
          if (input_valid) load = 1'b1;
          else             state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    if (load) begin
      a_d                   = '0;
      b_d                   = '0;
      a_d[WORD_WIDTH-1:0]   = A;
      b_d[WORD_WIDTH-1:0]   = B;
      sign_a_d              = A[WORD_WIDTH-1];
      sign_b_d              = B[WORD_WIDTH-1];
      cnt_d                 = CNT_LAST;
      state_d               = CALC;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= LOAD;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= CNT_LAST;
      eq_q     <= 1'b0;
      ltu_q    <= 1'b0;
      gtu_q    <= 1'b0;
      lts_q    <= 1'b0;
      gts_q    <= 1'b0;
    end else if (clock_enable) begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      eq_q     <= eq_d;
      ltu_q    <= ltu_d;
      gtu_q    <= gtu_d;
      lts_q    <= lts_d;
      gts_q    <= gts_d;
    end
  end

  assign input_ready     = (state_q == LOAD);
  assign output_valid    = (state_q == DONE);
  assign A_eq_B          = eq_q;
  assign A_lt_B_unsigned = ltu_q;
  assign A_gt_B_unsigned = gtu_q;
  assign A_lt_B_signed   = lts_q;
  assign A_gt_B_signed   = gts_q;
endmodule

// File: tb/tb_comparator_binary_multiprecision.sv
// Scoreboard bench: two instances (128/16 and 20/8) checked against an arithmetic model.
module tb_comparator_binary_multiprecision;
  localparam int W1 = 128, S1 = 16;
  localparam int W2 = 20,  S2 = 8;

  typedef struct { logic [4:0] f; int lat; int hs; } exp_t;  // f = {eq,ltu,gtu,lts,gts}

  logic clock = 1'b0;
  logic clear = 1'b1, ce = 1'b1;
  always #5 clock = ~clock;

  logic          iv1 = 0, or1 = 0, ir1, ov1, eq1, ltu1, gtu1, lts1, gts1;
  logic [W1-1:0] a1 = '0, b1 = '0;
  logic          iv2 = 0, or2 = 0, ir2, ov2, eq2, ltu2, gtu2, lts2, gts2;
  logic [W2-1:0] a2 = '0, b2 = '0;

  comparator_binary_multiprecision #(.WORD_WIDTH(W1), .STEP_WORD_WIDTH(S1)) dut1 (
    .clock(clock), .clear(clear), .clock_enable(ce), .input_valid(iv1), .input_ready(ir1),
    .A(a1), .B(b1), .output_valid(ov1), .output_ready(or1), .A_eq_B(eq1),
    .A_lt_B_unsigned(ltu1), .A_gt_B_unsigned(gtu1), .A_lt_B_signed(lts1), .A_gt_B_signed(gts1));

  comparator_binary_multiprecision #(.WORD_WIDTH(W2), .STEP_WORD_WIDTH(S2)) dut2 (
    .clock(clock), .clear(clear), .clock_enable(ce), .input_valid(iv2), .input_ready(ir2),
    .A(a2), .B(b2), .output_valid(ov2), .output_ready(or2), .A_eq_B(eq2),
    .A_lt_B_unsigned(ltu2), .A_gt_B_unsigned(gtu2), .A_lt_B_signed(lts2), .A_gt_B_signed(gts2));

  int tests = 0, fails = 0, cyc = 0;
  exp_t q1[$], q2[$];
  logic [4:0] last1 = '0, last2 = '0, o1, o2;
  logic held1 = 0, held2 = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Values taken as w-bit unsigned and two's complement; latency = words scanned from the top.
  function automatic exp_t model(input logic [127:0] a, input logic [127:0] b, input int w, input int s);
    exp_t e;
    logic signed [129:0] sa, sb;
    logic [127:0] x;
    int h, n;
    n  = (w + s - 1) / s;
    sa = $signed({2'b00, a}) - (a[w-1] ? $signed(130'd1 << w) : 130'sd0);
    sb = $signed({2'b00, b}) - (b[w-1] ? $signed(130'd1 << w) : 130'sd0);
    e.f = {a == b, a < b, a > b, sa < sb, sa > sb};
    x = a ^ b;
    h = -1;
    for (int i = 0; i < 128; i++) if (x[i]) h = i;
    e.lat = (h < 0) ? n : n - h / s;
    e.hs  = 0;
    return e;
  endfunction

  always @(posedge clock) if (ce) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    o1 = {eq1, ltu1, gtu1, lts1, gts1};
    if (ov1) begin
      if (q1.size() == 0) chk("spurious_valid1", q1.size(), 1);
      else begin
        if (!held1) chk("latency1", cyc - q1[0].hs, q1[0].lat);
        chk(held1 ? "held1" : "result1", o1, q1[0].f);
        if (or1 && ce && !clear) begin last1 = q1[0].f; void'(q1.pop_front()); held1 = 0; end
        else held1 = 1;
      end
    end else begin
      held1 = 0;
      chk("idle_hold1", o1, last1);
    end
    if (!clear && ce && iv1 && (ir1 || (ov1 && or1))) begin
      e = model(128'(a1), 128'(b1), W1, S1);
      e.hs = cyc + 1;
      q1.push_back(e);
    end
    if (clear) begin q1.delete(); last1 = '0; held1 = 0; end
  end

  always @(negedge clock) begin
    exp_t e;
    o2 = {eq2, ltu2, gtu2, lts2, gts2};
    if (ov2) begin
      if (q2.size() == 0) chk("spurious_valid2", q2.size(), 1);
      else begin
        if (!held2) chk("latency2", cyc - q2[0].hs, q2[0].lat);
        chk(held2 ? "held2" : "result2", o2, q2[0].f);
        if (or2 && ce && !clear) begin last2 = q2[0].f; void'(q2.pop_front()); held2 = 0; end
        else held2 = 1;
      end
    end else begin
      held2 = 0;
      chk("idle_hold2", o2, last2);
    end
    if (!clear && ce && iv2 && (ir2 || (ov2 && or2))) begin
      e = model(128'(a2), 128'(b2), W2, S2);
      e.hs = cyc + 1;
      q2.push_back(e);
    end
    if (clear) begin q2.delete(); last2 = '0; held2 = 0; end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ov1();
    int n = 0;
    while (!ov1 && n < 64) begin tick(); n++; end
    if (!ov1) chk("timeout1", ov1, 1);
  endtask

  task automatic wait_ov2();
    int n = 0;
    while (!ov2 && n < 64) begin tick(); n++; end
    if (!ov2) chk("timeout2", ov2, 1);
  endtask

  // Operands are scrambled after the handshake; the captured values must win.
  task automatic run1(input logic [127:0] a, input logic [127:0] b);
    iv1 = 1; a1 = a; b1 = b; tick();
    iv1 = 0; a1 = ~a; b1 = b ^ 128'h1;
    wait_ov1();
    or1 = 1; tick(); or1 = 0;
  endtask

  task automatic run2(input logic [W2-1:0] a, input logic [W2-1:0] b);
    iv2 = 1; a2 = a; b2 = b; tick();
    iv2 = 0; a2 = ~a; b2 = b ^ 20'h1;
    wait_ov2();
    or2 = 1; tick(); or2 = 0;
  endtask

  task automatic gen(input int w, input int s, output logic [127:0] a, output logic [127:0] b);
    logic [127:0] mask;
    int k, mode;
    mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
    mode = $urandom_range(0, 3);
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    case (mode)
      1: b = a;
      2: begin
        k = $urandom_range(0, (w + s - 1) / s - 1);
        b = a ^ ((128'($urandom | 1) & ((128'd1 << s) - 128'd1)) << (k * s));
      end
      3: begin a = 128'($urandom_range(0, 15)); b = 128'($urandom_range(0, 15)); end
      default: ;
    endcase
    a &= mask;
    b &= mask;
  endtask

  initial begin
    logic [127:0] ra, rb;
    clear = 1; tick(); tick(); clear = 0;
    chk("rst_ready1", ir1, 1);
    chk("rst_valid1", ov1, 0);
    chk("rst_out1", {eq1, ltu1, gtu1, lts1, gts1}, 0);
    chk("rst_ready2", ir2, 1);
    chk("rst_valid2", ov2, 0);

    run1(128'h0123456789ABCDEF0123456789ABCDEF, 128'h0123456789ABCDEF0123456789ABCDEF);
    run1(128'h80000000000000000000000000000000, 128'h1);
    run1(128'd5, 128'd7);
    run1(128'hFFFF0000000000000000000000000000, 128'h7FFF0000000000000000000000000001);
    run2(20'hFFFFF, 20'h7FFFF);
    run2(20'hABCDE, 20'hABCDE);
    run2(20'h7FFFF, 20'h80000);

    // Hold in DONE for 5 cycles, then read-and-load the next pair with no LOAD in between.
    iv1 = 1; a1 = 128'h1234; b1 = 128'h1234_0000_0000_0000_0000; tick();
    iv1 = 0; wait_ov1();
    repeat (5) tick();
    chk("held_valid1", ov1, 1);
    iv1 = 1; a1 = 128'hFFFF_FFFF; b1 = 128'hFFFF_FFFE; or1 = 1; tick();
    iv1 = 0; or1 = 0;
    chk("rnl_ready1", ir1, 0);
    chk("rnl_calc1", ov1, 0);
    wait_ov1();
    or1 = 1; tick(); or1 = 0;

    // Clear in the middle of a long compare.
    iv1 = 1; a1 = 128'd5; b1 = 128'd7; tick();
    iv1 = 0; repeat (3) tick();
    clear = 1; tick(); clear = 0;
    chk("clr_ready1", ir1, 1);
    chk("clr_valid1", ov1, 0);
    chk("clr_out1", {eq1, ltu1, gtu1, lts1, gts1}, 0);
    run1(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0);

    for (int i = 0; i < 3000; i++) begin
      ce  = ($urandom_range(0, 7) != 0);
      iv1 = $urandom_range(0, 1);
      or1 = ($urandom_range(0, 2) != 0);
      gen(W1, S1, ra, rb); a1 = ra; b1 = rb;
      iv2 = $urandom_range(0, 1);
      or2 = ($urandom_range(0, 2) != 0);
      gen(W2, S2, ra, rb); a2 = ra[W2-1:0]; b2 = rb[W2-1:0];
      tick();
    end
    ce = 1; iv1 = 0; iv2 = 0; or1 = 1; or2 = 1;
    repeat (30) tick();
    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
